// File: rtl/datapath_pkg.sv
// Shared encodings for the datapath: ALU op, writeback select, B shifter, multiplier FSM.
// Latency: n/a (types only).
// Backpressure: n/a.
package datapath_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_NOT  = 3'b011,
        ALU_OR   = 3'b100,
        ALU_XOR  = 3'b101,
        ALU_MUL  = 3'b110,
        ALU_PASS = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        VSEL_MDATA = 2'b00,
        VSEL_IMM8  = 2'b01,
        VSEL_PC    = 2'b10,
        VSEL_C     = 2'b11
    } vsel_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } mul_state_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// Latency: busy for exactly WIDTH cycles after start; done pulses the cycle after the last one.
// Backpressure: start is only accepted in IDLE; the caller must hold off while busy.
module mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               last,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    import datapath_pkg::*;

    localparam int CW = $clog2(WIDTH + 1);

    mul_state_e         state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    // product is the accumulator after this cycle's step; during 'last' it is the full result
    assign product = mplier[0] ? (acc + mcand) : acc;

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // next-state: start launches, the final iteration returns to idle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_MUL;
            ST_MUL:  if (last)  state_nxt = ST_IDLE;
        endcase
    end

    // outputs decoded from state and iteration count
    always_comb begin
        busy = (state == ST_MUL);
        last = (state == ST_MUL) && (cnt == CW'(WIDTH - 1));
    end

    // shift-add datapath and the one-cycle done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            done   <= 1'b0;
        end else begin
            done <= last;
            if (state == ST_IDLE && start) begin
                cnt    <= '0;
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
            end else if (state == ST_MUL) begin
                cnt    <= cnt + 1'b1;
                acc    <= product;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
        end
    end

endmodule

// File: rtl/datapath_gen.sv
// Register file, B shifter, ALU and A/B/C/status registers; optional multiplier via DATAPATH_MUL_EN.
// Latency: single-cycle ops land in C one edge after loadc; MUL holds busy WIDTH cycles then pulses done.
// Backpressure: while busy, loada/loadb/loadc/loads are ignored; write and readnum stay live.
module datapath_gen #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int PC_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         sximm8,
    input  logic [WIDTH-1:0]         sximm5,
    input  logic [WIDTH-1:0]         mdata,
    input  logic [PC_W-1:0]          PC,
    input  logic [$clog2(NREGS)-1:0] readnum,
    input  logic [$clog2(NREGS)-1:0] writenum,
    input  logic                     write,
    input  logic [1:0]               vsel,
    input  logic                     loada,
    input  logic                     loadb,
    input  logic                     loadc,
    input  logic                     loads,
    input  logic                     asel,
    input  logic                     bsel,
    input  logic [1:0]               shift,
    input  logic [2:0]               ALUop,
    output logic [WIDTH-1:0]         datapath_out,
    output logic                     N_out,
    output logic                     V_out,
    output logic                     Z_out,
    output logic                     busy,
    output logic                     done
);
    import datapath_pkg::*;

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] rd_dat;
    logic [WIDTH-1:0] wb_dat;
    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic [WIDTH-1:0] b_sh, ain, bin, alu_res;
    logic             alu_ovf;
    logic             n_q, v_q, z_q;
    logic             is_mul;
    logic             sc_ok;
    alu_op_e          op;
    vsel_e            wsel;
    shift_e           sh;

    assign op   = alu_op_e'(ALUop);
    assign wsel = vsel_e'(vsel);
    assign sh   = shift_e'(shift);

    assign rd_dat       = regs[readnum];
    assign datapath_out = c_q;
    assign N_out        = n_q;
    assign V_out        = v_q;
    assign Z_out        = z_q;

`ifdef DATAPATH_MUL_EN
    logic               mul_start;
    logic               mul_last;
    logic               mul_ld_s;
    logic [2*WIDTH-1:0] mul_prod;

    assign is_mul    = (op == ALU_MUL);
    assign mul_start = !busy && loadc && is_mul;

    mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (ain),
        .b       (bin),
        .busy    (busy),
        .last    (mul_last),
        .done    (done),
        .product (mul_prod)
    );
`else
    // without the multiplier ALUop 110 behaves as pass-Bin and never stalls
    assign is_mul = 1'b0;
    assign busy   = 1'b0;
    assign done   = 1'b0;
`endif

    // single-cycle results only commit when idle and the op is not a launched multiply
    assign sc_ok = !busy && !is_mul;

    // writeback source select; PC is zero-extended
    always_comb begin
        wb_dat = mdata;
        case (wsel)
            VSEL_MDATA: wb_dat = mdata;
            VSEL_IMM8:  wb_dat = sximm8;
            VSEL_PC:    wb_dat = WIDTH'(PC);
            VSEL_C:     wb_dat = c_q;
        endcase
    end

    // B shifter and operand muxes
    always_comb begin
        b_sh = b_q;
        case (sh)
            SH_NONE: b_sh = b_q;
            SH_LSL1: b_sh = {b_q[WIDTH-2:0], 1'b0};
            SH_LSR1: b_sh = {1'b0, b_q[WIDTH-1:1]};
            SH_ASR1: b_sh = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
        endcase
        ain = asel ? '0 : a_q;
        bin = bsel ? sximm5 : b_sh;
    end

    // ALU; MUL shares the pass-Bin leg because the real product comes from mul_iter
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            ALU_ADD: begin
                alu_res = ain + bin;
                alu_ovf = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = ain - bin;
                alu_ovf = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
            end
            ALU_AND:           alu_res = ain & bin;
            ALU_NOT:           alu_res = ~bin;
            ALU_OR:            alu_res = ain | bin;
            ALU_XOR:           alu_res = ain ^ bin;
            ALU_MUL, ALU_PASS: alu_res = bin;
        endcase
    end

    // register file write port; reset clears every entry
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (write) begin
            regs[writenum] <= wb_dat;
        end
    end

    // A/B/C/status registers, including multiply launch and completion
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            n_q <= 1'b0;
            v_q <= 1'b0;
            z_q <= 1'b0;
`ifdef DATAPATH_MUL_EN
            mul_ld_s <= 1'b0;
`endif
        end else begin
            if (!busy && loada) a_q <= rd_dat;
            if (!busy && loadb) b_q <= rd_dat;
            if (sc_ok && loadc) c_q <= alu_res;
            if (sc_ok && loads) begin
                z_q <= (alu_res == '0);
                n_q <= alu_res[WIDTH-1];
                v_q <= alu_ovf;
            end
`ifdef DATAPATH_MUL_EN
            if (mul_start) mul_ld_s <= loads;
            if (mul_last) begin
                c_q <= mul_prod[WIDTH-1:0];
                if (mul_ld_s) begin
                    z_q <= (mul_prod[WIDTH-1:0] == '0);
                    n_q <= mul_prod[WIDTH-1];
                    v_q <= (mul_prod[2*WIDTH-1:WIDTH] != '0);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_datapath_gen.sv
// Bench for datapath_gen: random and directed stimulus against an arithmetic reference model.
// Latency: model steps once per clock edge; outputs sampled 1ns after the edge.
// Backpressure: model tracks the multiply countdown and drops loads while it runs.
module tb_datapath_gen;

`ifdef DATAPATH_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sximm8, sximm5, mdata;
    logic [7:0]  PC;
    logic [2:0]  readnum, writenum;
    logic        write;
    logic [1:0]  vsel, shift;
    logic        loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  ALUop;
    logic [15:0] dout;
    logic        n_out, v_out, z_out, busy, done;

    logic [31:0] w_sximm8, w_sximm5, w_mdata;
    logic [3:0]  w_readnum, w_writenum;
    logic [31:0] w_out;
    logic        w_n, w_v, w_z, w_busy, w_done;

    int n_checks = 0;
    int n_errors = 0;

    // reference state
    logic [15:0] m_rf [8];
    logic [15:0] m_a, m_b, m_c;
    logic        m_n, m_v, m_z, m_done, m_mls;
    logic [31:0] m_prod;
    int          m_rem;

    always #5 clk = ~clk;

    datapath_gen #(.WIDTH(16), .NREGS(8), .PC_W(8)) u_dut (
        .clk(clk), .reset(reset), .sximm8(sximm8), .sximm5(sximm5), .mdata(mdata), .PC(PC),
        .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
        .shift(shift), .ALUop(ALUop), .datapath_out(dout), .N_out(n_out), .V_out(v_out),
        .Z_out(z_out), .busy(busy), .done(done)
    );

    datapath_gen #(.WIDTH(32), .NREGS(16), .PC_W(8)) u_dut32 (
        .clk(clk), .reset(reset), .sximm8(w_sximm8), .sximm5(w_sximm5), .mdata(w_mdata), .PC(PC),
        .readnum(w_readnum), .writenum(w_writenum), .write(write), .vsel(vsel),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
        .shift(shift), .ALUop(ALUop), .datapath_out(w_out), .N_out(w_n), .V_out(w_v),
        .Z_out(w_z), .busy(w_busy), .done(w_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one clock edge of the reference behaviour, using the inputs currently applied
    task automatic model_edge();
        logic [15:0] rd, bsh, ain, bin, res, wb;
        int          s;
        bit          ovf;
        if (reset) begin
            foreach (m_rf[i]) m_rf[i] = '0;
            m_a = '0; m_b = '0; m_c = '0;
            m_n = 0; m_v = 0; m_z = 0; m_done = 0; m_mls = 0;
            m_rem = 0;
            return;
        end
        rd = m_rf[readnum];
        case (shift)
            2'd0:    bsh = m_b;
            2'd1:    bsh = m_b << 1;
            2'd2:    bsh = m_b >> 1;
            default: bsh = $signed(m_b) >>> 1;
        endcase
        ain = asel ? 16'h0000 : m_a;
        bin = bsel ? sximm5 : bsh;
        ovf = 0;
        case (ALUop)
            3'd0: begin
                res = ain + bin;
                s   = int'($signed(ain)) + int'($signed(bin));
                ovf = (s > 32767) || (s < -32768);
            end
            3'd1: begin
                res = ain - bin;
                s   = int'($signed(ain)) - int'($signed(bin));
                ovf = (s > 32767) || (s < -32768);
            end
            3'd2:    res = ain & bin;
            3'd3:    res = ~bin;
            3'd4:    res = ain | bin;
            3'd5:    res = ain ^ bin;
            default: res = bin;
        endcase
        case (vsel)
            2'd0:    wb = mdata;
            2'd1:    wb = sximm8;
            2'd2:    wb = {8'h00, PC};
            default: wb = m_c;
        endcase
        m_done = 0;
        if (write) m_rf[writenum] = wb;
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_c = m_prod[15:0];
                if (m_mls) begin
                    m_z = (m_prod[15:0] == 16'h0000);
                    m_n = m_prod[15];
                    m_v = (m_prod[31:16] != 16'h0000);
                end
                m_done = 1;
            end
        end else begin
            if (MUL_EN && ALUop == 3'd6) begin
                if (loadc) begin
                    m_prod = {16'h0000, ain} * {16'h0000, bin};
                    m_rem  = 16;
                    m_mls  = loads;
                end
            end else begin
                if (loadc) m_c = res;
                if (loads) begin
                    m_z = (res == 16'h0000);
                    m_n = res[15];
                    m_v = ovf;
                end
            end
            if (loada) m_a = rd;
            if (loadb) m_b = rd;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("dout", {16'h0, dout}, {16'h0, m_c});
        check("n", n_out, m_n);
        check("v", v_out, m_v);
        check("z", z_out, m_z);
        check("busy", busy, m_rem > 0);
        check("done", done, m_done);
    endtask

    task automatic clr_ctl();
        reset = 0; write = 0; vsel = 0; shift = 0; ALUop = 0;
        loada = 0; loadb = 0; loadc = 0; loads = 0; asel = 0; bsel = 0;
    endtask

    task automatic wr_reg(input logic [2:0] r, input logic [15:0] v);
        clr_ctl();
        vsel = 2'd1; sximm8 = v; writenum = r; write = 1;
        step();
        write = 0;
    endtask

    task automatic ld_ab(input logic [2:0] ra, input logic [2:0] rb);
        clr_ctl();
        readnum = ra; loada = 1; step(); loada = 0;
        readnum = rb; loadb = 1; step(); loadb = 0;
    endtask

    task automatic start_mul();
        clr_ctl();
        ALUop = 3'd6; loadc = 1; loads = 1;
        step();
        clr_ctl();
    endtask

    task automatic rand_inputs();
        reset    = ($urandom_range(0, 49) == 0);
        sximm8   = 16'($urandom);
        sximm5   = 16'($urandom);
        mdata    = 16'($urandom);
        PC       = 8'($urandom);
        readnum  = 3'($urandom);
        writenum = 3'($urandom);
        write    = 1'($urandom);
        vsel     = 2'($urandom);
        shift    = 2'($urandom);
        ALUop    = 3'($urandom);
        loada    = 1'($urandom);
        loadb    = 1'($urandom);
        loadc    = 1'($urandom);
        loads    = 1'($urandom);
        asel     = 1'($urandom);
        bsel     = 1'($urandom);
    endtask

    initial begin
        int          nb, nd;
        logic [15:0] dd;

        clr_ctl();
        sximm8 = 0; sximm5 = 0; mdata = 0; PC = 0; readnum = 0; writenum = 0;
        w_sximm8 = 0; w_sximm5 = 0; w_mdata = 0; w_readnum = 0; w_writenum = 0;

        // reset state
        reset = 1; step(); reset = 0;
        check("rst_dout", {16'h0, dout}, 32'h0);
        check("rst_busy", busy, 1'b0);

        // write immediate, add small immediate
        wr_reg(3'd1, 16'h1234);
        clr_ctl(); readnum = 3'd1; loada = 1; step();
        clr_ctl(); bsel = 1; sximm5 = 16'h0001; ALUop = 3'd0; loadc = 1; step();
        check("add_imm", {16'h0, dout}, 32'h1235);

        // signed overflow on subtract
        wr_reg(3'd2, 16'h7FFF);
        wr_reg(3'd3, 16'hFFFF);
        ld_ab(3'd2, 3'd3);
        clr_ctl(); ALUop = 3'd1; loadc = 1; loads = 1; step();
        check("sub_out", {16'h0, dout}, 32'h8000);
        check("sub_n", n_out, 1'b1);
        check("sub_v", v_out, 1'b1);
        check("sub_z", z_out, 1'b0);

        // multiply with an ignored loadc during busy
        wr_reg(3'd2, 16'h0012);
        wr_reg(3'd3, 16'h0034);
        ld_ab(3'd2, 3'd3);
        start_mul();
        nb = busy ? 1 : 0; nd = 0; dd = 16'h0;
        for (int k = 0; k < 20; k++) begin
            ALUop = 3'd0; loadc = busy; loads = busy;
            step();
            if (busy) nb++;
            if (done) begin nd++; dd = dout; end
        end
        clr_ctl();
        check("mul_busy_cycles", nb, MUL_EN ? 32'd16 : 32'd0);
        check("mul_done_pulses", nd, MUL_EN ? 32'd1 : 32'd0);
        check("mul_done_out", {16'h0, dd}, MUL_EN ? 32'h03A8 : 32'h0);
        check("mul_out", {16'h0, dout}, MUL_EN ? 32'h03A8 : 32'h0034);
        check("mul_v", v_out, 1'b0);
        check("mul_z", z_out, 1'b0);

        // product whose low half is zero
        wr_reg(3'd2, 16'h0100);
        wr_reg(3'd3, 16'h0100);
        ld_ab(3'd2, 3'd3);
        start_mul();
        for (int k = 0; k < 20; k++) step();
        check("mul_hi_out", {16'h0, dout}, MUL_EN ? 32'h0 : 32'h0100);
        check("mul_hi_v", v_out, MUL_EN);
        check("mul_hi_z", z_out, MUL_EN);

        // reset on the fifth busy cycle aborts the multiply
        wr_reg(3'd2, 16'h0012);
        wr_reg(3'd3, 16'h0034);
        ld_ab(3'd2, 3'd3);
        start_mul();
        for (int k = 0; k < 4; k++) step();
        reset = 1; step(); reset = 0;
        check("abort_busy", busy, 1'b0);
        check("abort_dout", {16'h0, dout}, 32'h0);
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (done) nd++;
        end
        check("abort_no_done", nd, 32'd0);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            rand_inputs();
            step();
        end

        // 32-bit instance: mdata into R15, arithmetic shift right, add from zero
        clr_ctl(); reset = 1; step(); reset = 0;
        check("w32_rst_out", w_out, 32'h0);
        clr_ctl(); vsel = 2'd0; w_mdata = 32'hDEADBEEF; w_writenum = 4'd15; write = 1; step();
        clr_ctl(); w_readnum = 4'd15; loadb = 1; step();
        clr_ctl(); shift = 2'd3; asel = 1; ALUop = 3'd0; loadc = 1; loads = 1; step();
        check("w32_asr_out", w_out, 32'hEF56DF77);
        check("w32_asr_n", w_n, 1'b1);
        check("w32_asr_v", w_v, 1'b0);
        check("w32_asr_z", w_z, 1'b0);
        check("w32_busy", w_busy, 1'b0);
        check("w32_done", w_done, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
